// File: rtl/forward_scoreboard.sv
// Operand forward unit with a long-latency-unit pending scoreboard.
// Picks the youngest matching in-flight stage per read port, falls back to
// the LU writeback, raises load-use / LU-busy stalls and counts stall cycles.
module forward_scoreboard #(
    parameter int NREAD  = 2,
    parameter int NSTAGE = 2,
    parameter int REGW   = 5,
    parameter int SELW   = $clog2(NSTAGE + 2),
    parameter int CNTW   = 32
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [NREAD*REGW-1:0]   id_rsel,
    input  logic [NREAD-1:0]        id_ren,
    input  logic [NSTAGE*REGW-1:0]  stage_rd,
    input  logic [NSTAGE-1:0]       stage_wen,
    input  logic [NSTAGE-1:0]       stage_rdy,
    input  logic                    lu_issue,
    input  logic [REGW-1:0]         lu_issue_rd,
    input  logic                    lu_done,
    input  logic [REGW-1:0]         lu_done_rd,
    input  logic                    lu_flush,
    output logic [NREAD*SELW-1:0]   forward_sel,
    output logic                    stall,
    output logic                    lu_issue_ok,
    output logic [2**REGW-1:0]      pending,
    output logic [CNTW-1:0]         stall_count
);

    localparam logic [SELW-1:0] SEL_LU = SELW'(NSTAGE + 1);

    logic [2**REGW-1:0] pending_nxt;

    // Per-port forward select and hazard detection.
    always_comb begin
        logic [REGW-1:0] rsel;
        logic [SELW-1:0] sel;
        logic            covered;
        logic            sel_rdy;
        forward_sel = '0;
        stall       = 1'b0;
        for (int i = 0; i < NREAD; i++) begin
            rsel    = id_rsel[i*REGW +: REGW];
            sel     = '0;
            covered = 1'b0;
            sel_rdy = 1'b1;
            // Walk oldest to youngest so the youngest match overwrites.
            for (int k = NSTAGE - 1; k >= 0; k--) begin
                if (stage_wen[k] && (stage_rd[k*REGW +: REGW] == rsel)) begin
                    sel     = SELW'(k + 1);
                    covered = 1'b1;
                    sel_rdy = stage_rdy[k];
                end
            end
            if (!covered && lu_done && (lu_done_rd == rsel)) begin
                sel     = SEL_LU;
                covered = 1'b1;
            end
            if (id_ren[i] && (rsel != '0)) begin
                forward_sel[i*SELW +: SELW] = sel;
                if (!sel_rdy || (pending[rsel] && !covered))
                    stall = 1'b1;
            end
        end
    end

    // LU issue is allowed when the destination is idle or retiring this cycle.
    always_comb begin
        lu_issue_ok = (lu_issue_rd == '0) || !pending[lu_issue_rd] ||
                      (lu_done && (lu_done_rd == lu_issue_rd));
    end

    // Next scoreboard: flush, else clear on done then set on issue.
    always_comb begin
        pending_nxt = pending;
        if (lu_flush) begin
            pending_nxt = '0;
        end else begin
            if (lu_done)
                pending_nxt[lu_done_rd] = 1'b0;
            if (lu_issue && (lu_issue_rd != '0))
                pending_nxt[lu_issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // Scoreboard and saturating stall counter registers.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            pending     <= '0;
            stall_count <= '0;
        end else begin
            pending <= pending_nxt;
            if (stall && (stall_count != {CNTW{1'b1}}))
                stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Bench for forward_scoreboard: directed scenarios followed by random traffic,
// all compared against a rule-level reference model.
module tb_forward_scoreboard;

    localparam int NR = 2;
    localparam int NS = 2;
    localparam int RW = 5;
    localparam int SW = 2;
    localparam int CW = 5;
    localparam int NREG = 32;
    localparam int CMAX = 31;

    logic               CLK;
    logic               nRST;
    logic [NR*RW-1:0]   id_rsel;
    logic [NR-1:0]      id_ren;
    logic [NS*RW-1:0]   stage_rd;
    logic [NS-1:0]      stage_wen;
    logic [NS-1:0]      stage_rdy;
    logic               lu_issue;
    logic [RW-1:0]      lu_issue_rd;
    logic               lu_done;
    logic [RW-1:0]      lu_done_rd;
    logic               lu_flush;
    logic [NR*SW-1:0]   forward_sel;
    logic               stall;
    logic               lu_issue_ok;
    logic [NREG-1:0]    pending;
    logic [CW-1:0]      stall_count;

    int checks = 0;
    int failures = 0;

    bit m_pend [NREG];
    int m_cnt;

    forward_scoreboard #(
        .NREAD(NR), .NSTAGE(NS), .REGW(RW), .SELW(SW), .CNTW(CW)
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .id_rsel(id_rsel), .id_ren(id_ren),
        .stage_rd(stage_rd), .stage_wen(stage_wen), .stage_rdy(stage_rdy),
        .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd),
        .lu_done(lu_done), .lu_done_rd(lu_done_rd), .lu_flush(lu_flush),
        .forward_sel(forward_sel), .stall(stall), .lu_issue_ok(lu_issue_ok),
        .pending(pending), .stall_count(stall_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int rsel_of(int p);
        return int'(id_rsel[p*RW +: RW]);
    endfunction

    // Youngest writing stage wins, then LU writeback, else regfile.
    function automatic int m_sel(int p);
        int r;
        r = rsel_of(p);
        if (!id_ren[p] || r == 0) return 0;
        for (int k = 1; k <= NS; k++)
            if (stage_wen[k-1] && int'(stage_rd[(k-1)*RW +: RW]) == r) return k;
        if (lu_done && int'(lu_done_rd) == r) return NS + 1;
        return 0;
    endfunction

    function automatic bit m_stall();
        int r;
        int s;
        for (int p = 0; p < NR; p++) begin
            r = rsel_of(p);
            if (id_ren[p] && r != 0) begin
                s = m_sel(p);
                if (s >= 1 && s <= NS && !stage_rdy[s-1]) return 1'b1;
                if (m_pend[r] && s == 0) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic bit m_issue_ok();
        int r;
        r = int'(lu_issue_rd);
        if (r == 0 || !m_pend[r]) return 1'b1;
        return lu_done && int'(lu_done_rd) == r;
    endfunction

    function automatic logic [NREG-1:0] m_pend_vec();
        logic [NREG-1:0] v;
        for (int j = 0; j < NREG; j++) v[j] = m_pend[j];
        return v;
    endfunction

    task automatic clear_in();
        id_rsel = '0; id_ren = '0;
        stage_rd = '0; stage_wen = '0; stage_rdy = '0;
        lu_issue = 1'b0; lu_issue_rd = '0;
        lu_done = 1'b0; lu_done_rd = '0; lu_flush = 1'b0;
    endtask

    // Compare every output against the model, away from the clock edge.
    task automatic settle();
        #4;
        for (int p = 0; p < NR; p++)
            chk($sformatf("fsel%0d", p), 64'(forward_sel[p*SW +: SW]), 64'(m_sel(p)));
        chk("stall", 64'(stall), 64'(m_stall()));
        chk("issue_ok", 64'(lu_issue_ok), 64'(m_issue_ok()));
        chk("pending", 64'(pending), 64'(m_pend_vec()));
        chk("stall_count", 64'(stall_count), 64'(m_cnt));
    endtask

    // Apply the clock edge to the model, then to the DUT.
    task automatic advance();
        bit st;
        st = m_stall();
        if (!nRST) begin
            foreach (m_pend[j]) m_pend[j] = 1'b0;
            m_cnt = 0;
        end else begin
            if (st && m_cnt < CMAX) m_cnt++;
            if (lu_flush) begin
                foreach (m_pend[j]) m_pend[j] = 1'b0;
            end else begin
                if (lu_done) m_pend[lu_done_rd] = 1'b0;
                if (lu_issue && lu_issue_rd != 0) m_pend[lu_issue_rd] = 1'b1;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    initial begin
        clear_in();
        nRST = 1'b0;
        foreach (m_pend[j]) m_pend[j] = 1'b0;
        m_cnt = 0;
        @(posedge CLK);
        #1;
        settle();
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_count", 64'(stall_count), 64'd0);
        chk("idle_ok", 64'(lu_issue_ok), 64'd1);
        advance();
        nRST = 1'b1;

        // Stage priority
        id_rsel[0 +: RW] = 5; id_ren = 2'b01;
        stage_rd = {5'd5, 5'd5}; stage_wen = 2'b11; stage_rdy = 2'b11;
        settle();
        chk("prio_s1", 64'(forward_sel[0 +: SW]), 64'd1);
        chk("prio_nostall", 64'(stall), 64'd0);
        advance();
        stage_wen = 2'b10;
        settle();
        chk("prio_s2", 64'(forward_sel[0 +: SW]), 64'd2);
        advance();

        // Load-use
        clear_in();
        stage_rd[0 +: RW] = 7; stage_wen = 2'b01; stage_rdy = 2'b00;
        id_rsel[RW +: RW] = 7; id_ren = 2'b10;
        settle();
        chk("lduse_stall", 64'(stall), 64'd1);
        chk("lduse_fsel1", 64'(forward_sel[SW +: SW]), 64'd1);
        advance();
        stage_rdy = 2'b01;
        settle();
        chk("lduse_clear", 64'(stall), 64'd0);
        chk("lduse_count", 64'(stall_count), 64'd1);
        advance();

        // Older ready stage must not hide a younger not-ready one
        stage_rd = {5'd7, 5'd7}; stage_wen = 2'b11; stage_rdy = 2'b10;
        settle();
        chk("lduse_young", 64'(stall), 64'd1);
        advance();

        // LU busy
        clear_in();
        lu_issue = 1'b1; lu_issue_rd = 9;
        cycle();
        clear_in();
        id_rsel[0 +: RW] = 9; id_ren = 2'b01;
        settle();
        chk("lu_busy", 64'(stall), 64'd1);
        chk("lu_pend9", 64'(pending[9]), 64'd1);
        advance();
        lu_done = 1'b1; lu_done_rd = 9;
        settle();
        chk("lu_fwd", 64'(forward_sel[0 +: SW]), 64'd3);
        chk("lu_done_nostall", 64'(stall), 64'd0);
        advance();
        clear_in();
        settle();
        chk("lu_pend9_clr", 64'(pending[9]), 64'd0);
        advance();

        // Same-cycle issue and done, then flush
        lu_issue = 1'b1; lu_issue_rd = 12;
        cycle();
        lu_done = 1'b1; lu_done_rd = 12;
        settle();
        chk("same_ok", 64'(lu_issue_ok), 64'd1);
        advance();
        clear_in();
        settle();
        chk("same_pend12", 64'(pending[12]), 64'd1);
        advance();
        lu_flush = 1'b1; lu_issue = 1'b1; lu_issue_rd = 14;
        cycle();
        clear_in();
        settle();
        chk("flush_pend", 64'(pending), 64'd0);
        advance();

        // x0 and disabled ports
        id_rsel[0 +: RW] = 0; id_ren = 2'b01;
        stage_rd = '0; stage_wen = 2'b01; stage_rdy = 2'b00;
        settle();
        chk("x0_fsel", 64'(forward_sel[0 +: SW]), 64'd0);
        chk("x0_stall", 64'(stall), 64'd0);
        advance();
        clear_in();
        lu_issue = 1'b1; lu_issue_rd = 4;
        cycle();
        clear_in();
        id_rsel[0 +: RW] = 4; id_ren = 2'b00;
        settle();
        chk("ren0_stall", 64'(stall), 64'd0);
        advance();
        lu_issue = 1'b1; lu_issue_rd = 0;
        cycle();
        clear_in();
        settle();
        chk("x0_issue", 64'(pending), 64'h10);
        advance();

        // Reset mid-operation
        lu_flush = 1'b1;
        cycle();
        clear_in();
        lu_issue = 1'b1; lu_issue_rd = 3;
        cycle();
        clear_in();
        id_rsel[0 +: RW] = 3; id_ren = 2'b01;
        nRST = 1'b0;
        cycle();
        nRST = 1'b1;
        lu_issue = 1'b1; lu_issue_rd = 3;
        id_ren = 2'b00;
        cycle();
        lu_issue = 1'b0;
        id_ren = 2'b01;
        for (int n = 0; n < 10; n++) cycle();
        settle();
        chk("pre_rst_count", 64'(stall_count), 64'd10);
        chk("pre_rst_pend3", 64'(pending[3]), 64'd1);
        nRST = 1'b0;
        advance();
        nRST = 1'b1;
        settle();
        chk("post_rst_pend", 64'(pending), 64'd0);
        chk("post_rst_count", 64'(stall_count), 64'd0);
        advance();

        // Saturation
        lu_issue = 1'b1; lu_issue_rd = 3; id_ren = 2'b00;
        cycle();
        lu_issue = 1'b0; id_ren = 2'b01;
        for (int n = 0; n < 40; n++) cycle();
        settle();
        chk("sat_count", 64'(stall_count), 64'(CMAX));
        advance();

        // Random traffic over a small register range to provoke matches
        clear_in();
        lu_flush = 1'b1;
        cycle();
        for (int n = 0; n < 400; n++) begin
            nRST        = ($urandom_range(0, 59) != 0);
            id_rsel     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            id_ren      = 2'($urandom);
            stage_rd    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            stage_wen   = 2'($urandom);
            stage_rdy   = 2'($urandom) | 2'($urandom);
            lu_issue    = ($urandom_range(0, 3) == 0);
            lu_issue_rd = 5'($urandom_range(0, 7));
            lu_done     = ($urandom_range(0, 3) == 0);
            lu_done_rd  = 5'($urandom_range(0, 7));
            lu_flush    = ($urandom_range(0, 39) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/forward_scoreboard.md
Name: forward_scoreboard

Overview:
- Parametrised successor to the single-stage EX operand forward unit.
- Resolves operand forwarding for NREAD read ports across NSTAGE in-flight pipeline stages plus one long-latency unit (LU) writeback, e.g. a divider.
- Keeps a per-register pending scoreboard for LU destinations. Generates load-use and LU-busy stalls, and counts stall cycles.
- Sits beside the decode/EX boundary; outputs feed the EX operand muxes and the hazard/stall logic.

Parameters:
- NREAD, 2, number of operand read ports.
- NSTAGE, 2, number of forwarding stages; stage 1 is youngest (MEM), stage NSTAGE is oldest (WB).
- REGW, 5, register index width; register file has 2**REGW entries.
- SELW, $clog2(NSTAGE+2), width of each forward select field.
- CNTW, 32, stall counter width.

Ports:
- CLK  in  1  clock
- nRST  in  1  synchronous active-low reset
- id_rsel  in  NREAD*REGW  source register per read port; port i at bits [i*REGW +: REGW]
- id_ren  in  NREAD  read port i uses its operand
- stage_rd  in  NSTAGE*REGW  destination register of each stage
- stage_wen  in  NSTAGE  stage k writes stage_rd[k]
- stage_rdy  in  NSTAGE  stage k's result is available for forwarding; 0 for a load still in MEM
- lu_issue  in  1  LU operation accepted this cycle
- lu_issue_rd  in  REGW  LU destination register
- lu_done  in  1  LU result valid this cycle
- lu_done_rd  in  REGW  LU completing destination register
- lu_flush  in  1  cancel all outstanding LU operations
- forward_sel  out  NREAD*SELW  per port: 0 = regfile, k = stage k (1..NSTAGE), NSTAGE+1 = LU result
- stall  out  1  decode must hold
- lu_issue_ok  out  1  LU issue to lu_issue_rd is permitted
- pending  out  2**REGW  scoreboard bitmap
- stall_count  out  CNTW  saturating count of stalled cycles

Behaviour:
- Clock and reset: single clock CLK. nRST is synchronous, active-low. Reset clears pending to 0 and stall_count to 0.
- Combinational outputs: forward_sel, stall and lu_issue_ok are combinational from inputs and current state; they carry no reset value of their own. With pending=0 and all enables low: forward_sel=0, stall=0, lu_issue_ok=1.
- Register x0: never forwarded, never marked pending, never causes a stall. Ignore any match on index 0.
- Forward select, per port i with id_ren[i]=1 and rsel != 0:
  - Scan stages 1..NSTAGE and pick the lowest k with stage_wen[k] and stage_rd[k]==rsel.
  - Otherwise, if lu_done and lu_done_rd==rsel, select NSTAGE+1.
  - Otherwise select 0.
  - A port with id_ren[i]=0 always gets forward_sel 0.
- Stall: asserted if any enabled port i with rsel != 0 meets either condition:
  - (a) the selected stage k has stage_rdy[k]=0 (load-use). An older ready stage does not override a younger not-ready match.
  - (b) pending[rsel]=1, and neither a stage match nor lu_done with lu_done_rd==rsel covers it this cycle.
- Scoreboard update, at the clock edge, evaluated in this order:
  - lu_flush clears every bit.
  - Otherwise, lu_done clears pending[lu_done_rd].
  - Then lu_issue with lu_issue_rd != 0 sets pending[lu_issue_rd].
  - Issue and done to the same register in the same cycle leaves the bit set.
  - lu_issue together with lu_flush: flush wins and the bit stays clear.
- lu_issue_ok = !pending[lu_issue_rd] || (lu_done && lu_done_rd==lu_issue_rd). Rd 0 is always OK. Issuing while lu_issue_ok=0 is a caller error: the bit stays set and no assertion fires in RTL.
- lu_done for a non-pending register: its value is still forwarded; the scoreboard is unchanged.
- stall_count increments by 1 on each clock edge where stall=1 and nRST=1. It saturates at all-ones and does not wrap.
- Reset asserted mid-operation clears all pending bits; any LU operation in flight is forgotten. Its later lu_done only forwards.

Test Plan:
- Stage priority: id_rsel0=5, stage_rd={1:5, 2:5}, both wen/rdy=1 -> forward_sel0=1, stall=0. Drop stage1 wen -> forward_sel0=2.
- Load-use: stage1 rd=7, wen=1, rdy=0; port1 rsel=7, ren=1 -> stall=1, forward_sel1=1. Next cycle with rdy=1 -> stall=0. stall_count=1.
- LU busy: lu_issue rd=9; next cycle port0 rsel=9 -> stall=1, pending[9]=1. lu_done rd=9 -> forward_sel0=3, stall=0; pending[9]=0 after the edge.
- Same-cycle issue+done to rd 12 with pending[12]=1 -> lu_issue_ok=1, pending[12] still 1 after the edge. lu_flush -> pending=0.
- x0 and disabled ports: rsel=0 with stage_rd=0 wen=1 rdy=0 -> forward_sel=0, stall=0. ren=0 with a matching pending register -> no stall. lu_issue rd=0 -> pending unchanged.
- Reset mid-op: pending[3]=1, stall_count=10, nRST low for one edge -> pending=0, stall_count=0. Force stall_count to all-ones, hold stall -> stays all-ones.
